// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK link (modulator and demodulator).
// Contents: FSM state encoding, default frame length, tone constants,
// the link configuration record and the repetition-vote helper.
package fsk_pkg;

    localparam int unsigned NBITS_DEFAULT = 128;

    // Tone select encoding on the freq line.
    localparam logic TONE_888 = 1'b0;
    localparam logic TONE_936 = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitCarrier,
        StSample,
        StFinish
    } fsk_state_t;

    typedef struct packed {
        logic [15:0] symbol_time;
        logic [3:0]  repetition_factor;
    } fsk_cfg_t;

    // Majority decision: 1 only when strictly more than half the repetitions
    // were 936 MHz, so an even split resolves to 0.
    function automatic logic vote_bit(input logic [3:0] ones, input logic [3:0] reps);
        return {ones, 1'b0} > {1'b0, reps};
    endfunction

endpackage

// File: rtl/fsk_sym_timer.sv
// Symbol timer for the FSK demodulator.
// Ports:
//   clk_12mhz_int, M_RESET_B   clock, async active-low reset
//   start                      clears cycle and repetition counters
//   run                        advances the counters while high
//   symbol_time                cycles per repetition (T, >= 2)
//   repetition_factor          repetitions per bit (R, >= 1)
//   sample_strobe              cycle counter at T>>1
//   bit_strobe                 sample_strobe of the last repetition of a bit
module fsk_sym_timer (
    input  logic        clk_12mhz_int,
    input  logic        M_RESET_B,
    input  logic        start,
    input  logic        run,
    input  logic [15:0] symbol_time,
    input  logic [3:0]  repetition_factor,
    output logic        sample_strobe,
    output logic        bit_strobe
);

    logic [15:0] cyc_cnt_q;
    logic [3:0]  rep_cnt_q;
    logic        cyc_wrap;
    logic        rep_last;

    assign cyc_wrap = (cyc_cnt_q == symbol_time - 16'd1);
    assign rep_last = (rep_cnt_q == repetition_factor - 4'd1);

    always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            cyc_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else if (start) begin
            cyc_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else if (run) begin
            cyc_cnt_q <= cyc_wrap ? 16'd0 : cyc_cnt_q + 16'd1;
            if (cyc_wrap) begin
                rep_cnt_q <= rep_last ? 4'd0 : rep_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        sample_strobe = run && (cyc_cnt_q == (symbol_time >> 1));
        bit_strobe    = sample_strobe && rep_last;
    end

endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator: recovers an NBITS frame from carrier/tone indications,
// majority-voting R repetitions of T cycles each, MSB received first.
// Ports:
//   clk_12mhz_int, M_RESET_B   12 MHz clock, async active-low reset
//   carrier_in, freq_in        asynchronous front-end indications
//   symbol_time                cycles per repetition, captured at arm
//   repetition_factor          repetitions per bit (0 means 1), captured at arm
//   arm                        request to listen for one frame
//   busy                       armed and not yet finished/aborted
//   bitstream_out              last complete frame
//   valid                      one-cycle pulse, frame complete
//   abort                      one-cycle pulse, carrier lost at a sample point
//   vote_err_count             non-unanimous votes in the current/last frame
module fsk_demodulator
    import fsk_pkg::*;
#(
    parameter int unsigned NBITS       = NBITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_12mhz_int,
    input  logic             M_RESET_B,
    input  logic             carrier_in,
    input  logic             freq_in,
    input  logic [15:0]      symbol_time,
    input  logic [3:0]       repetition_factor,
    input  logic             arm,
    output logic             busy,
    output logic [NBITS-1:0] bitstream_out,
    output logic             valid,
    output logic             abort,
    output logic [7:0]       vote_err_count
);

    localparam int unsigned BCW = $clog2(NBITS);

    logic [SYNC_STAGES-1:0] carrier_sync_q;
    logic [SYNC_STAGES-1:0] freq_sync_q;
    logic                   carrier_prev_q;
    logic                   carrier_s;
    logic                   freq_s;

    fsk_state_t             state_q;
    fsk_cfg_t               cfg_q;
    logic [3:0]             ones_q;
    logic [3:0]             ones_next;
    logic [BCW-1:0]         bit_cnt_q;
    logic [NBITS-1:0]       shift_q;

    logic                   timer_start;
    logic                   timer_run;
    logic                   sample_strobe;
    logic                   bit_strobe;

    always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            carrier_sync_q <= '0;
            freq_sync_q    <= '0;
            carrier_prev_q <= 1'b0;
        end else begin
            carrier_sync_q <= (carrier_sync_q << 1) | SYNC_STAGES'(carrier_in);
            freq_sync_q    <= (freq_sync_q << 1) | SYNC_STAGES'(freq_in);
            carrier_prev_q <= carrier_s;
        end
    end

    always_comb begin
        carrier_s   = carrier_sync_q[SYNC_STAGES-1];
        freq_s      = freq_sync_q[SYNC_STAGES-1];
        ones_next   = ones_q + {3'b000, (freq_s == TONE_936)};
        // Frame timing starts on a carrier rising edge, not a level.
        timer_start = (state_q == StWaitCarrier) && carrier_s && !carrier_prev_q;
        timer_run   = (state_q == StSample);
    end

    fsk_sym_timer u_sym_timer (
        .clk_12mhz_int     (clk_12mhz_int),
        .M_RESET_B         (M_RESET_B),
        .start             (timer_start),
        .run               (timer_run),
        .symbol_time       (cfg_q.symbol_time),
        .repetition_factor (cfg_q.repetition_factor),
        .sample_strobe     (sample_strobe),
        .bit_strobe        (bit_strobe)
    );

    always_ff @(posedge clk_12mhz_int or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            state_q        <= StIdle;
            cfg_q          <= '0;
            ones_q         <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            busy           <= 1'b0;
            valid          <= 1'b0;
            abort          <= 1'b0;
            bitstream_out  <= '0;
            vote_err_count <= '0;
        end else begin
            valid <= 1'b0;
            abort <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (arm && (symbol_time >= 16'd2)) begin
                        cfg_q.symbol_time       <= symbol_time;
                        cfg_q.repetition_factor <= (repetition_factor == 4'd0) ? 4'd1
                                                                              : repetition_factor;
                        ones_q         <= '0;
                        bit_cnt_q      <= '0;
                        vote_err_count <= '0;
                        busy           <= 1'b1;
                        state_q        <= StWaitCarrier;
                    end
                end
                StWaitCarrier: begin
                    if (timer_start) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    if (sample_strobe) begin
                        if (!carrier_s) begin
                            abort   <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else if (bit_strobe) begin
                            shift_q <= {shift_q[NBITS-2:0],
                                        vote_bit(ones_next, cfg_q.repetition_factor)};
                            ones_q  <= '0;
                            if ((ones_next != 4'd0) && (ones_next != cfg_q.repetition_factor)
                                && (vote_err_count != 8'hFF)) begin
                                vote_err_count <= vote_err_count + 8'd1;
                            end
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                            if (bit_cnt_q == BCW'(NBITS - 1)) begin
                                state_q <= StFinish;
                            end
                        end else begin
                            ones_q <= ones_next;
                        end
                    end
                end
                StFinish: begin
                    bitstream_out <= shift_q;
                    valid         <= 1'b1;
                    busy          <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: drives inputs on the falling edge,
// observes outputs on the falling edge, one task per scenario.
module tb_fsk_demodulator;

    localparam int NB = 128;

    logic          clk_12mhz_int = 1'b0;
    logic          M_RESET_B;
    logic          carrier_in;
    logic          freq_in;
    logic [15:0]   symbol_time;
    logic [3:0]    repetition_factor;
    logic          arm;
    logic          busy;
    logic [NB-1:0] bitstream_out;
    logic          valid;
    logic          abort;
    logic [7:0]    vote_err_count;

    fsk_demodulator #(
        .NBITS       (NB),
        .SYNC_STAGES (2)
    ) dut (
        .clk_12mhz_int     (clk_12mhz_int),
        .M_RESET_B         (M_RESET_B),
        .carrier_in        (carrier_in),
        .freq_in           (freq_in),
        .symbol_time       (symbol_time),
        .repetition_factor (repetition_factor),
        .arm               (arm),
        .busy              (busy),
        .bitstream_out     (bitstream_out),
        .valid             (valid),
        .abort             (abort),
        .vote_err_count    (vote_err_count)
    );

    always #5 clk_12mhz_int = ~clk_12mhz_int;

    int cyc = 0;
    always @(posedge clk_12mhz_int) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;

    // Pulse monitor: records when valid/abort were seen and busy alongside.
    int   valid_cnt = 0;
    int   valid_cyc = 0;
    logic busy_at_valid = 1'b0;
    int   abort_cnt = 0;
    int   abort_cyc = 0;
    logic busy_at_abort = 1'b0;

    always @(negedge clk_12mhz_int) begin
        if (valid === 1'b1) begin
            valid_cnt     = valid_cnt + 1;
            valid_cyc     = cyc;
            busy_at_valid = busy;
        end
        if (abort === 1'b1) begin
            abort_cnt     = abort_cnt + 1;
            abort_cyc     = cyc;
            busy_at_abort = busy;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_arm(input logic [15:0] t, input logic [3:0] r);
        symbol_time       = t;
        repetition_factor = r;
        arm               = 1'b1;
        @(negedge clk_12mhz_int);
        arm = 1'b0;
    endtask

    // Transmitter model, called on a falling edge. Each repetition holds
    // freq_in for t cycles. flip inverts repetition 1 of marked bits,
    // tie_bit is sent as (1,0), drop_bit drops the carrier and stops,
    // stop_bit stops with the lines left as they are, arm_bit pulses a
    // second arm (symbol_time 30) at the start of that bit.
    task automatic tx_frame(input logic [NB-1:0] data, input int t, input int r,
                            input logic [NB-1:0] flip, input int tie_bit,
                            input int drop_bit, input int stop_bit, input int arm_bit,
                            output int c0);
        int   reps;
        logic f;
        reps = (r == 0) ? 1 : r;
        c0   = cyc;
        for (int i = 0; i < NB; i++) begin
            if (i == stop_bit) return;
            if (i == drop_bit) begin
                carrier_in = 1'b0;
                return;
            end
            for (int j = 0; j < reps; j++) begin
                f = data[NB-1-i];
                if (flip[NB-1-i] && j == 1) f = ~f;
                if (i == tie_bit) f = (j == 0);
                carrier_in = 1'b1;
                freq_in    = f;
                for (int c = 0; c < t; c++) begin
                    arm = (i == arm_bit) && (j == 0) && (c == 0);
                    if (arm) symbol_time = 16'd30;
                    @(negedge clk_12mhz_int);
                end
                arm = 1'b0;
            end
        end
        carrier_in = 1'b0;
        freq_in    = 1'b0;
    endtask

    task automatic test_reset();
        M_RESET_B         = 1'b0;
        carrier_in        = 1'b0;
        freq_in           = 1'b0;
        symbol_time       = 16'd0;
        repetition_factor = 4'd0;
        arm               = 1'b0;
        repeat (3) @(negedge clk_12mhz_int);
        n_cmp++;
        if ({busy, valid, abort, vote_err_count, bitstream_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_in: got busy=%b valid=%b abort=%b err=%0d bits=%h need all 0",
                     busy, valid, abort, vote_err_count, bitstream_out);
        end
        M_RESET_B = 1'b1;
        repeat (3) @(negedge clk_12mhz_int);
        n_cmp++;
        if ({busy, valid, abort, vote_err_count, bitstream_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got busy=%b valid=%b abort=%b err=%0d bits=%h need all 0",
                     busy, valid, abort, vote_err_count, bitstream_out);
        end
    endtask

    task automatic test_unanimous();
        logic [NB-1:0] data;
        int c0, n0, exp_cyc;
        data = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        n0   = valid_cnt;
        do_arm(16'd100, 4'd1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL unan_busy_rise: got %b need 1", busy);
        end
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(data, 100, 1, '0, -1, -1, -1, -1, c0);
        for (int k = 0; k < 400 && valid_cnt == n0; k++) @(negedge clk_12mhz_int);
        // 2 sync stages + edge detect put t0 three edges after the first drive.
        exp_cyc = c0 + 5 + (NB * 1 - 1) * 100 + 50;
        n_cmp++;
        if (valid_cnt !== n0 + 1) begin
            n_bad++;
            $display("FAIL unan_valid_count: got %0d need 1", valid_cnt - n0);
        end
        n_cmp++;
        if (valid_cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL unan_valid_cycle: got %0d need %0d", valid_cyc - c0, exp_cyc - c0);
        end
        n_cmp++;
        if (bitstream_out !== data) begin
            n_bad++;
            $display("FAIL unan_data: got %h need %h", bitstream_out, data);
        end
        n_cmp++;
        if (vote_err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL unan_err: got %0d need 0", vote_err_count);
        end
        n_cmp++;
        if (busy_at_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL unan_busy_fall: got %b need 0", busy_at_valid);
        end
    endtask

    task automatic test_majority();
        logic [NB-1:0] data;
        int c0, n0, exp_cyc;
        data = 128'h0123456789ABCDEF_FEDCBA9876543210;
        n0   = valid_cnt;
        do_arm(16'd40, 4'd3);
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(data, 40, 3, {16{8'h80}}, -1, -1, -1, -1, c0);
        for (int k = 0; k < 400 && valid_cnt == n0; k++) @(negedge clk_12mhz_int);
        exp_cyc = c0 + 5 + (NB * 3 - 1) * 40 + 20;
        n_cmp++;
        if (valid_cnt !== n0 + 1 || valid_cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL maj_valid: got count %0d at %0d need 1 at %0d",
                     valid_cnt - n0, valid_cyc - c0, exp_cyc - c0);
        end
        n_cmp++;
        if (bitstream_out !== data) begin
            n_bad++;
            $display("FAIL maj_data: got %h need %h", bitstream_out, data);
        end
        n_cmp++;
        if (vote_err_count !== 8'd16) begin
            n_bad++;
            $display("FAIL maj_err: got %0d need 16", vote_err_count);
        end
    endtask

    task automatic test_tie();
        logic [NB-1:0] data;
        logic [NB-1:0] exp_data;
        int c0, n0;
        data     = {4{32'hA5A5A5A5}};
        exp_data = {32'hA1A5A5A5, {3{32'hA5A5A5A5}}};
        n0       = valid_cnt;
        do_arm(16'd10, 4'd2);
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(data, 10, 2, '0, 5, -1, -1, -1, c0);
        for (int k = 0; k < 400 && valid_cnt == n0; k++) @(negedge clk_12mhz_int);
        n_cmp++;
        if (valid_cnt !== n0 + 1) begin
            n_bad++;
            $display("FAIL tie_valid_count: got %0d need 1", valid_cnt - n0);
        end
        n_cmp++;
        if (bitstream_out !== exp_data) begin
            n_bad++;
            $display("FAIL tie_data: got %h need %h", bitstream_out, exp_data);
        end
        n_cmp++;
        if (vote_err_count !== 8'd1) begin
            n_bad++;
            $display("FAIL tie_err: got %0d need 1", vote_err_count);
        end
    endtask

    task automatic test_carrier_loss();
        logic [NB-1:0] prev;
        int c0, nv, na, exp_cyc;
        prev = {32'hA1A5A5A5, {3{32'hA5A5A5A5}}};
        nv   = valid_cnt;
        na   = abort_cnt;
        do_arm(16'd20, 4'd1);
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1234_5678, 20, 1, '0, -1, 57, -1, -1, c0);
        for (int k = 0; k < 100 && abort_cnt == na; k++) @(negedge clk_12mhz_int);
        repeat (50) @(negedge clk_12mhz_int);
        exp_cyc = c0 + 4 + 57 * 20 + 10;
        n_cmp++;
        if (abort_cnt !== na + 1) begin
            n_bad++;
            $display("FAIL loss_abort_count: got %0d need 1", abort_cnt - na);
        end
        n_cmp++;
        if (abort_cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL loss_abort_cycle: got %0d need %0d", abort_cyc - c0, exp_cyc - c0);
        end
        n_cmp++;
        if (busy_at_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL loss_busy: got %b need 0", busy_at_abort);
        end
        n_cmp++;
        if (valid_cnt !== nv) begin
            n_bad++;
            $display("FAIL loss_no_valid: got %0d pulses need 0", valid_cnt - nv);
        end
        n_cmp++;
        if (bitstream_out !== prev) begin
            n_bad++;
            $display("FAIL loss_retain: got %h need %h", bitstream_out, prev);
        end
    endtask

    task automatic test_arm_rules();
        logic [NB-1:0] data;
        logic          busy_seen;
        int c0, n0, exp_cyc;
        data      = 128'hFEED_FACE_0BAD_F00D_1357_9BDF_2468_ACE0;
        busy_seen = 1'b0;
        do_arm(16'd1, 4'd1);
        for (int k = 0; k < 6; k++) begin
            busy_seen = busy_seen | busy;
            @(negedge clk_12mhz_int);
        end
        n_cmp++;
        if (busy_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL arm_illegal: got busy %b need 0", busy_seen);
        end
        n0 = valid_cnt;
        do_arm(16'd10, 4'd1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arm_legal_busy: got %b need 1", busy);
        end
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(data, 10, 1, '0, -1, -1, -1, 20, c0);
        for (int k = 0; k < 400 && valid_cnt == n0; k++) @(negedge clk_12mhz_int);
        exp_cyc = c0 + 5 + (NB * 1 - 1) * 10 + 5;
        n_cmp++;
        if (valid_cnt !== n0 + 1 || valid_cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL arm_overlap_valid: got count %0d at %0d need 1 at %0d",
                     valid_cnt - n0, valid_cyc - c0, exp_cyc - c0);
        end
        n_cmp++;
        if (bitstream_out !== data) begin
            n_bad++;
            $display("FAIL arm_overlap_data: got %h need %h", bitstream_out, data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [NB-1:0] data;
        int c0, nv, na, exp_cyc;
        data = 128'h8000_0000_0000_0001_7FFF_FFFF_C3C3_3C3C;
        do_arm(16'd20, 4'd1);
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 20, 1, '0, -1, -1, 30, -1, c0);
        nv         = valid_cnt;
        na         = abort_cnt;
        M_RESET_B  = 1'b0;
        carrier_in = 1'b0;
        freq_in    = 1'b0;
        #1;
        n_cmp++;
        if ({busy, valid, abort, vote_err_count, bitstream_out} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got busy=%b valid=%b abort=%b err=%0d bits=%h need 0",
                     busy, valid, abort, vote_err_count, bitstream_out);
        end
        repeat (3) @(negedge clk_12mhz_int);
        M_RESET_B = 1'b1;
        repeat (60) @(negedge clk_12mhz_int);
        n_cmp++;
        if (valid_cnt !== nv || abort_cnt !== na) begin
            n_bad++;
            $display("FAIL rst_mid_pulses: got valid %0d abort %0d need 0 0",
                     valid_cnt - nv, abort_cnt - na);
        end
        do_arm(16'd12, 4'd0);
        repeat (3) @(negedge clk_12mhz_int);
        tx_frame(data, 12, 0, '0, -1, -1, -1, -1, c0);
        for (int k = 0; k < 400 && valid_cnt == nv; k++) @(negedge clk_12mhz_int);
        exp_cyc = c0 + 5 + (NB * 1 - 1) * 12 + 6;
        n_cmp++;
        if (valid_cnt !== nv + 1 || valid_cyc !== exp_cyc) begin
            n_bad++;
            $display("FAIL r0_valid: got count %0d at %0d need 1 at %0d",
                     valid_cnt - nv, valid_cyc - c0, exp_cyc - c0);
        end
        n_cmp++;
        if (bitstream_out !== data) begin
            n_bad++;
            $display("FAIL r0_data: got %h need %h", bitstream_out, data);
        end
    endtask

    initial begin
        @(negedge clk_12mhz_int);
        test_reset();
        test_unanimous();
        test_majority();
        test_tie();
        test_carrier_loss();
        test_arm_rules();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
